// File: rtl/uart_cmd_responder.sv
// Framed command responder on the UART byte stream: parses SYNC/CMD/ADDR/LEN/DATA/CHK,
// performs byte writes/reads on a memory port and answers with ACK/NAK or read data.
module uart_cmd_responder #(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              frame_err
);
    localparam logic [7:0] SYNC   = 8'hAA;
    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;
    localparam logic [7:0] ACK    = 8'h06;
    localparam logic [7:0] NAK    = 8'h15;
    localparam int         TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ADDR, S_LEN, S_DATA, S_CHK, S_RSP,
        S_TX_SEND, S_TX_WAIT_HI, S_TX_WAIT_LO, S_RD_REQ, S_RD_CAP
    } state_t;

    // Which response byte the transmit handshake is currently carrying
    typedef enum logic [2:0] {
        PH_SINGLE, PH_SYNC, PH_CMD, PH_LEN, PH_DATA, PH_CHK
    } phase_t;

    state_t            state, state_next;
    phase_t            phase;
    logic [7:0]        cmd;
    logic [7:0]        len;
    logic [7:0]        cnt;
    logic [7:0]        chk;
    logic              chk_ok;
    logic [ADDR_W-1:0] addr;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              in_frame;
    logic              timeout;

    assign in_frame = state inside {S_CMD, S_ADDR, S_LEN, S_DATA, S_CHK};
    assign timeout  = in_frame && !rx_valid && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        tx_start   = 1'b0;
        mem_re     = 1'b0;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (rx_valid && rx_data == SYNC) state_next = S_CMD;
            end
            S_CMD:  if (rx_valid) state_next = S_ADDR;
            S_ADDR: if (rx_valid) state_next = S_LEN;
            S_LEN:  if (rx_valid) state_next = (cmd == CMD_WR && rx_data != 8'd0) ? S_DATA : S_CHK;
            S_DATA: if (rx_valid && cnt == 8'd1) state_next = S_CHK;
            S_CHK:  if (rx_valid) state_next = S_RSP;
            S_RSP:  if (!tx_busy) state_next = S_TX_SEND;
            S_TX_SEND: begin
                tx_start   = 1'b1;
                state_next = S_TX_WAIT_HI;
            end
            S_TX_WAIT_HI: if (tx_busy) state_next = S_TX_WAIT_LO;
            S_TX_WAIT_LO: begin
                if (!tx_busy) begin
                    case (phase)
                        PH_SYNC, PH_CMD: state_next = S_TX_SEND;
                        PH_LEN, PH_DATA: state_next = (cnt != 8'd0) ? S_RD_REQ : S_TX_SEND;
                        default:         state_next = S_IDLE;
                    endcase
                end
            end
            S_RD_REQ: begin
                mem_re     = 1'b1;
                state_next = S_RD_CAP;
            end
            S_RD_CAP: state_next = S_TX_SEND;
            default:  state_next = S_IDLE;
        endcase
        if (timeout) state_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= PH_SINGLE;
            cmd       <= 8'd0;
            len       <= 8'd0;
            cnt       <= 8'd0;
            chk       <= 8'd0;
            chk_ok    <= 1'b0;
            addr      <= '0;
            tmo_cnt   <= '0;
            tx_data   <= 8'd0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'd0;
            frame_err <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            frame_err <= timeout;
            // Idle-gap counter: restarts on every byte inside a frame
            if (in_frame && !rx_valid && !timeout) tmo_cnt <= tmo_cnt + TMO_W'(1);
            else                                   tmo_cnt <= '0;

            case (state)
                S_IDLE: if (rx_valid && rx_data == SYNC) chk <= 8'd0;
                S_CMD: if (rx_valid) begin
                    cmd <= rx_data;
                    chk <= chk ^ rx_data;
                end
                S_ADDR: if (rx_valid) begin
                    addr <= ADDR_W'(rx_data);
                    chk  <= chk ^ rx_data;
                end
                S_LEN: if (rx_valid) begin
                    len <= rx_data;
                    cnt <= rx_data;
                    chk <= chk ^ rx_data;
                end
                S_DATA: if (rx_valid) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= addr;
                    mem_wdata <= rx_data;
                    addr      <= addr + ADDR_W'(1);
                    cnt       <= cnt - 8'd1;
                    chk       <= chk ^ rx_data;
                end
                S_CHK: if (rx_valid) chk_ok <= (chk == rx_data);
                S_RSP: if (!tx_busy) begin
                    if (!chk_ok || !(cmd == CMD_WR || cmd == CMD_RD)) begin
                        tx_data <= NAK;
                        phase   <= PH_SINGLE;
                    end else if (cmd == CMD_WR) begin
                        tx_data <= ACK;
                        phase   <= PH_SINGLE;
                    end else begin
                        // Response checksum covers 0x02, LEN and the data bytes
                        tx_data  <= SYNC;
                        phase    <= PH_SYNC;
                        chk      <= CMD_RD ^ len;
                        cnt      <= len;
                        mem_addr <= addr;
                    end
                end
                S_TX_WAIT_LO: if (!tx_busy) begin
                    case (phase)
                        PH_SYNC: begin
                            tx_data <= CMD_RD;
                            phase   <= PH_CMD;
                        end
                        PH_CMD: begin
                            tx_data <= len;
                            phase   <= PH_LEN;
                        end
                        PH_LEN, PH_DATA: begin
                            if (cnt == 8'd0) begin
                                tx_data <= chk;
                                phase   <= PH_CHK;
                            end else begin
                                phase   <= PH_DATA;
                            end
                        end
                        default: ;
                    endcase
                end
                S_RD_CAP: begin
                    tx_data  <= mem_rdata;
                    chk      <= chk ^ mem_rdata;
                    cnt      <= cnt - 8'd1;
                    mem_addr <= mem_addr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_responder.sv
// Bench for uart_cmd_responder: acts as host, memory and transmitter; a frame-level
// model predicts writes, reads and response bytes, checked every cycle.
module tb_uart_cmd_responder;
    localparam int T_OUT = 1000;

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [15:0] word_q_t[$];

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       mem_we;
    logic       mem_re;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       frame_err;

    uart_cmd_responder #(.ADDR_W(8), .TIMEOUT_CYCLES(T_OUT)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         last_rx = 0;
    int         n_total = 0;
    int         n_pass = 0;
    int         exp_ferr = 0;
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    byte_q_t    exp_tx;
    byte_q_t    exp_rd;
    word_q_t    exp_wr;
    byte_q_t    f;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input bit ok, input string name,
                                  input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endfunction

    function automatic logic [63:0] pack8(input byte_q_t q);
        logic [63:0] v;
        v = '0;
        foreach (q[i]) v = {v[55:0], q[i]};
        return v;
    endfunction

    function automatic logic [63:0] pack16(input word_q_t q);
        logic [63:0] v;
        v = '0;
        foreach (q[i]) v = {v[47:0], q[i]};
        return v;
    endfunction

    // Frame-level reference: what the device must write, read and send back
    task automatic model_frame(input byte_q_t fr);
        logic [7:0] cmd, a, len, x, d, r;
        int         n;
        cmd = fr[1];
        a   = fr[2];
        len = fr[3];
        n   = int'(len);
        x   = cmd ^ a ^ len;
        if (cmd == 8'h01) begin
            for (int i = 0; i < n; i++) begin
                d = fr[4 + i];
                x ^= d;
                exp_wr.push_back({a + 8'(i), d});
                ref_mem[a + 8'(i)] = d;
            end
        end
        if (x != fr[fr.size() - 1] || !(cmd == 8'h01 || cmd == 8'h02)) begin
            exp_tx.push_back(8'h15);
        end else if (cmd == 8'h01) begin
            exp_tx.push_back(8'h06);
        end else begin
            exp_tx.push_back(8'hAA);
            exp_tx.push_back(8'h02);
            exp_tx.push_back(len);
            r = 8'h02 ^ len;
            for (int i = 0; i < n; i++) begin
                d = ref_mem[a + 8'(i)];
                exp_rd.push_back(a + 8'(i));
                exp_tx.push_back(d);
                r ^= d;
            end
            exp_tx.push_back(r);
        end
    endtask

    function automatic byte_q_t make_frame(input logic [7:0] cmd, input logic [7:0] a,
                                           input logic [7:0] len, input bit bad);
        byte_q_t    fr;
        logic [7:0] x, d;
        fr.push_back(8'hAA);
        fr.push_back(cmd);
        fr.push_back(a);
        fr.push_back(len);
        x = cmd ^ a ^ len;
        if (cmd == 8'h01) begin
            for (int i = 0; i < int'(len); i++) begin
                d = 8'($urandom);
                fr.push_back(d);
                x ^= d;
            end
        end
        if (bad) x ^= 8'(1 << $urandom_range(0, 7));
        fr.push_back(x);
        return fr;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(posedge clk);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        last_rx  = cyc;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (k < 4000 && (exp_tx.size() != 0 || busy || tx_busy)) begin
            @(negedge clk);
            k++;
        end
        check(busy == 1'b0, {name, "_busy_low"}, 64'(busy), 64'd0);
        check(exp_tx.size() == 0 && exp_wr.size() == 0 && exp_rd.size() == 0,
              {name, "_pending"}, 64'(exp_tx.size() + exp_wr.size() + exp_rd.size()), 64'd0);
    endtask

    task automatic transmit(input byte_q_t fr, input bit inject, input string name);
        int k;
        for (int i = 0; i < fr.size(); i++) begin
            send_byte(fr[i], $urandom_range(0, 4));
            if (i == 0) check(busy == 1'b1, {name, "_busy_rise"}, 64'(busy), 64'd1);
        end
        if (inject) begin
            k = 0;
            while (k < 200 && !tx_start) begin
                @(negedge clk);
                k++;
            end
            send_byte(8'hAA, 0);
        end
        wait_idle(name);
    endtask

    task automatic check_zero(input string name);
        logic [63:0] v;
        v = 64'({tx_data, tx_start, mem_we, mem_re, mem_addr, mem_wdata, busy, frame_err});
        check(v == 64'd0, name, v, 64'd0);
    endtask

    // Memory: write on mem_we, return data one cycle after mem_re, junk otherwise
    initial begin
        logic       rd;
        logic [7:0] ra;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 5);
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            rd = mem_re;
            ra = mem_addr;
            if (mem_we) mem[mem_addr] = mem_wdata;
            @(posedge clk); #1;
            mem_rdata = rd ? mem[ra] : 8'($urandom);
        end
    end

    // Transmitter: busy rises the cycle after tx_start and holds a few cycles
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                @(posedge clk); #1;
                tx_busy = 1'b1;
                repeat ($urandom_range(2, 6)) @(posedge clk);
                #1;
                tx_busy = 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison of DUT strobes against the model queues
    initial begin
        logic        prev_tx;
        logic [15:0] ew;
        logic [7:0]  eb;
        prev_tx = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_we) begin
                    if (exp_wr.size() == 0) begin
                        check(exp_wr.size() != 0, "mem_we_unexpected", 64'({mem_addr, mem_wdata}), 64'd0);
                    end else begin
                        ew = exp_wr.pop_front();
                        check({mem_addr, mem_wdata} == ew && (cyc - last_rx) == 1, "mem_write",
                              64'({mem_addr, mem_wdata}), 64'(ew));
                    end
                end
                if (mem_re) begin
                    if (exp_rd.size() == 0) begin
                        check(exp_rd.size() != 0, "mem_re_unexpected", 64'(mem_addr), 64'd0);
                    end else begin
                        eb = exp_rd.pop_front();
                        check(mem_addr == eb, "mem_read_addr", 64'(mem_addr), 64'(eb));
                    end
                end
                if (tx_start) begin
                    if (exp_tx.size() == 0) begin
                        check(exp_tx.size() != 0, "tx_unexpected", 64'(tx_data), 64'd0);
                    end else begin
                        eb = exp_tx.pop_front();
                        check(tx_data == eb && !tx_busy && !prev_tx, "tx_byte",
                              64'({prev_tx, tx_busy, tx_data}), 64'(eb));
                    end
                end
                if (frame_err) begin
                    check(exp_ferr > 0 && (cyc - last_rx) >= T_OUT && (cyc - last_rx) <= T_OUT + 2,
                          "frame_err", 64'(cyc - last_rx), 64'(T_OUT + 1));
                    if (exp_ferr > 0) exp_ferr--;
                end
            end
            prev_tx = tx_start;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t exceeded limit 500000", $time);
        $fatal(1);
    end

    initial begin
        logic [7:0] cmd, a, len;
        int         k, r, n_st;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 5);
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_outputs");
        @(negedge clk);
        rst_n = 1'b1;

        // Noise before SYNC is dropped
        send_byte(8'h00, 1);
        send_byte(8'h55, 0);
        @(negedge clk);
        check(busy == 1'b0, "noise_ignored", 64'(busy), 64'd0);

        f = '{8'hAA, 8'h01, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h12};
        model_frame(f);
        check(pack8(exp_tx) == 64'h06, "pin_write_ack", pack8(exp_tx), 64'h06);
        check(pack16(exp_wr) == 64'h1011_1122_1233, "pin_write_list", pack16(exp_wr), 64'h1011_1122_1233);
        transmit(f, 1'b0, "write");
        check({mem[8'h10], mem[8'h11], mem[8'h12]} == 24'h112233, "write_mem",
              64'({mem[8'h10], mem[8'h11], mem[8'h12]}), 64'h112233);

        f = '{8'hAA, 8'h02, 8'h10, 8'h03, 8'h11};
        model_frame(f);
        check(pack8(exp_tx) == 64'hAA_02_03_11_22_33_01, "pin_read_seq", pack8(exp_tx), 64'hAA_02_03_11_22_33_01);
        check(pack8(exp_rd) == 64'h10_11_12, "pin_read_addr", pack8(exp_rd), 64'h10_11_12);
        transmit(f, 1'b0, "read");

        f = '{8'hAA, 8'h02, 8'h10, 8'h03, 8'h00};
        model_frame(f);
        check(pack8(exp_tx) == 64'h15 && exp_rd.size() == 0, "pin_bad_chk", pack8(exp_tx), 64'h15);
        transmit(f, 1'b0, "bad_chk");

        f = '{8'hAA, 8'h05, 8'h00, 8'h00, 8'h05};
        model_frame(f);
        check(pack8(exp_tx) == 64'h15, "pin_unknown_cmd", pack8(exp_tx), 64'h15);
        transmit(f, 1'b0, "unknown_cmd");

        f = '{8'hAA, 8'h01, 8'hFF, 8'h02, 8'hA5, 8'h5A, 8'h03};
        model_frame(f);
        check(pack16(exp_wr) == 64'hFFA5_005A, "pin_wrap_list", pack16(exp_wr), 64'hFFA5_005A);
        transmit(f, 1'b0, "wrap");
        check({mem[8'hFF], mem[8'h00]} == 16'hA55A, "wrap_mem", 64'({mem[8'hFF], mem[8'h00]}), 64'hA55A);

        f = '{8'hAA, 8'h02, 8'h40, 8'h00, 8'h42};
        model_frame(f);
        check(pack8(exp_tx) == 64'hAA_02_00_02, "pin_read_len0", pack8(exp_tx), 64'hAA_02_00_02);
        transmit(f, 1'b0, "read_len0");

        // Abandoned frame: exactly one frame_err, no response
        exp_ferr = 1;
        send_byte(8'hAA, 0);
        send_byte(8'h01, 0);
        k = 0;
        while (k < T_OUT + 50 && exp_ferr != 0) begin
            @(negedge clk);
            k++;
        end
        repeat (20) @(negedge clk);
        check(exp_ferr == 0 && busy == 1'b0, "timeout_return", 64'({exp_ferr[7:0], busy}), 64'd0);

        for (int n = 0; n < 40; n++) begin
            r   = $urandom_range(0, 9);
            cmd = (r < 4) ? 8'h01 : (r < 8) ? 8'h02 : 8'($urandom_range(3, 255));
            a   = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(248, 255));
            len = 8'($urandom_range(0, 6));
            f   = make_frame(cmd, a, len, $urandom_range(0, 3) == 0);
            model_frame(f);
            transmit(f, $urandom_range(0, 3) == 0, "random");
        end

        // Reset in the middle of a read response
        f = make_frame(8'h02, 8'h20, 8'd5, 1'b0);
        model_frame(f);
        for (int i = 0; i < f.size(); i++) send_byte(f[i], 0);
        k = 0;
        while (k < 200 && !tx_start) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("reset_mid_read");
        exp_tx.delete();
        exp_rd.delete();
        n_st = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_start) n_st++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_start) n_st++;
        end
        check(n_st == 0 && busy == 1'b0, "no_tx_after_reset", 64'({n_st[7:0], busy}), 64'd0);

        f = make_frame(8'h02, 8'hFE, 8'd4, 1'b0);
        model_frame(f);
        transmit(f, 1'b0, "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
